// File: rtl/simps_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simps_mode_ctrl
// Description : SIMPS top-level mode controller. Sequences the instrument
//               through reset, UFM program/readback, peripheral load,
//               inactive and active modes. Stages NUM_CH channel enables,
//               runs a per-state watchdog that traps into FAULT, and
//               provides clocked per-channel front-end overrides.
// Build macro : SIMPS_CTRL_OVERRIDE_EN - when defined, the override
//               registers and the ov_* ports are live; when undefined the
//               ov_* ports are ignored and no override flops are built.
// Revision    : 1.0 - initial release
// ============================================================================
module simps_mode_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int UFM_RST_CYC = 4,
  parameter int TIMEOUT     = 25000000,
  parameter int STAGE_DLY   = 256
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              sw_reset_rise_i,
  input  logic              sw_reset_i,
  input  logic              sw_enable_rise_i,
  input  logic              sw_enable_i,
  input  logic              init_done_i,
  input  logic              prog_ready_i,
  input  logic              write_done_i,
  input  logic              read_done_i,
  input  logic              load_done_i,
  input  logic              clk_stable_i,
  input  logic [NUM_CH-1:0] ov_set_i,
  input  logic [NUM_CH-1:0] ov_val_i,
  input  logic              ov_clear_i,
  output logic [NUM_CH-1:0] ch_en_o,
  output logic              ufm_reset_n_o,
  output logic              start_write_o,
  output logic              start_read_o,
  output logic              start_load_o,
  output logic [3:0]        state_o,
  output logic [1:0]        prog_led_o,
  output logic              fault_o
);

  localparam logic [3:0] c_RST_WAIT   = 4'd0;
  localparam logic [3:0] c_UFM_RST    = 4'd1;
  localparam logic [3:0] c_INIT_WAIT  = 4'd2;
  localparam logic [3:0] c_PROG_WRITE = 4'd3;
  localparam logic [3:0] c_PROG_READ  = 4'd4;
  localparam logic [3:0] c_LOAD       = 4'd5;
  localparam logic [3:0] c_INACTIVE   = 4'd6;
  localparam logic [3:0] c_ACTIVE     = 4'd7;
  localparam logic [3:0] c_FAULT      = 4'd8;

  localparam logic [1:0] c_LED_OFF   = 2'b00;
  localparam logic [1:0] c_LED_BLINK = 2'b01;
  localparam logic [1:0] c_LED_ON    = 2'b10;

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int STG_W = $clog2(NUM_CH * STAGE_DLY + 1);

  localparam logic [WD_W-1:0]  c_WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  c_UFM_LAST = WD_W'(UFM_RST_CYC - 1);
  localparam logic [STG_W-1:0] c_STG_MAX  = STG_W'(NUM_CH * STAGE_DLY);

  // Registered state and outputs
  logic [3:0]        state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [STG_W-1:0]  stg_q, stg_d;
  logic              seen_q, seen_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic              ufm_reset_n_q, ufm_reset_n_d;
  logic              start_write_q, start_write_d;
  logic              start_read_q, start_read_d;
  logic              start_load_q, start_load_d;
  logic [1:0]        prog_led_q, prog_led_d;
  logic              fault_q, fault_d;

  // Combinational helpers
  logic [NUM_CH-1:0] fsm_en_d;
  logic [NUM_CH-1:0] w_ch_mux;
  logic [NUM_CH-1:0] w_stage_hit;
  logic              w_staging;
  logic              w_wd_run;
  logic              w_wd_expire;
  logic              w_in_active;

  // Staging starts on the first clk_stable sample and is latched by seen_q,
  // so a later drop of clk_stable does not restart it.
  assign w_staging   = seen_q | clk_stable_i;
  assign w_wd_run    = ((state_q >= c_UFM_RST) && (state_q <= c_LOAD)) ||
                       ((state_q == c_ACTIVE) && !w_staging);
  assign w_wd_expire = w_wd_run && (wd_q == c_WD_LAST);

  // Channel k is due once the stage counter has covered k staging intervals.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_stage
    assign w_stage_hit[k] = (stg_q >= STG_W'(k * STAGE_DLY));
  end

  // State register and all registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= c_RST_WAIT;
      wd_q          <= '0;
      stg_q         <= '0;
      seen_q        <= 1'b0;
      ch_en_q       <= '0;
      ufm_reset_n_q <= 1'b0;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      start_load_q  <= 1'b0;
      prog_led_q    <= c_LED_BLINK;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      stg_q         <= stg_d;
      seen_q        <= seen_d;
      ch_en_q       <= ch_en_d;
      ufm_reset_n_q <= ufm_reset_n_d;
      start_write_q <= start_write_d;
      start_read_q  <= start_read_d;
      start_load_q  <= start_load_d;
      prog_led_q    <= prog_led_d;
      fault_q       <= fault_d;
    end
  end

  // Next state: switch reset beats watchdog expiry beats normal transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_RST_WAIT:   if (sw_enable_rise_i && sw_reset_i)     state_d = c_UFM_RST;
      c_UFM_RST:    if (wd_q == c_UFM_LAST)                 state_d = c_INIT_WAIT;
      c_INIT_WAIT:  if (init_done_i && prog_ready_i)        state_d = c_PROG_WRITE;
      c_PROG_WRITE: if (write_done_i)                       state_d = c_PROG_READ;
      c_PROG_READ:  if (read_done_i)                        state_d = c_LOAD;
      c_LOAD:       if (load_done_i && !sw_reset_i && !sw_enable_i)
                                                            state_d = c_INACTIVE;
      c_INACTIVE:   if (sw_enable_rise_i && !sw_reset_i)    state_d = c_ACTIVE;
      c_ACTIVE:     if (!sw_enable_i)                       state_d = c_PROG_READ;
      c_FAULT:                                              state_d = c_FAULT;
      default:                                              state_d = c_FAULT;
    endcase
    if (w_wd_expire) begin
      state_d = c_FAULT;
    end
    if (sw_reset_rise_i) begin
      state_d = c_RST_WAIT;
    end
  end

  // Watchdog, stage counter and the FSM's own channel enables
  always_comb begin
    w_in_active = (state_q == c_ACTIVE) && (state_d == c_ACTIVE);
    wd_d        = wd_q;
    stg_d       = stg_q;
    seen_d      = w_in_active && w_staging;
    fsm_en_d    = '0;
    if (sw_reset_rise_i || (state_d != state_q)) begin
      wd_d = '0;
    end else if (w_wd_run) begin
      wd_d = wd_q + 1'b1;
    end
    if (!w_in_active) begin
      stg_d = '0;
    end else if (w_staging && (stg_q != c_STG_MAX)) begin
      stg_d = stg_q + 1'b1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      fsm_en_d[k] = w_in_active && ((k == 0) || (w_staging && w_stage_hit[k]));
    end
  end

`ifdef SIMPS_CTRL_OVERRIDE_EN
  logic [NUM_CH-1:0] ov_act_q, ov_act_d;
  logic [NUM_CH-1:0] ov_reg_q, ov_reg_d;

  // Override capture: a clear (or switch reset) wipes every channel at once
  always_comb begin
    ov_act_d = ov_act_q;
    ov_reg_d = ov_reg_q;
    if (sw_reset_rise_i || ov_clear_i) begin
      ov_act_d = '0;
    end else begin
      ov_act_d = ov_act_q | ov_set_i;
      ov_reg_d = (ov_reg_q & ~ov_set_i) | (ov_val_i & ov_set_i);
    end
  end

  // Override registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ov_act_q <= '0;
      ov_reg_q <= '0;
    end else begin
      ov_act_q <= ov_act_d;
      ov_reg_q <= ov_reg_d;
    end
  end

  assign w_ch_mux = (ov_act_d & ov_reg_d) | (~ov_act_d & fsm_en_d);
`else
  logic unused_ov;
  assign unused_ov = ^{ov_set_i, ov_val_i, ov_clear_i};
  assign w_ch_mux  = fsm_en_d;
`endif

  // Registered outputs, all derived from the state being entered
  always_comb begin
    fault_d       = (state_d == c_FAULT);
    ufm_reset_n_d = !((state_d == c_RST_WAIT) || (state_d == c_UFM_RST));
    start_write_d = (state_q == c_INIT_WAIT) && (state_d == c_PROG_WRITE);
    start_read_d  = (state_d == c_PROG_READ) &&
                    ((state_q == c_PROG_WRITE) || (state_q == c_ACTIVE));
    start_load_d  = (state_q == c_PROG_READ) && (state_d == c_LOAD);
    ch_en_d       = fault_d ? '0 : w_ch_mux;
    case (state_d)
      c_RST_WAIT, c_UFM_RST, c_INIT_WAIT, c_PROG_WRITE: prog_led_d = c_LED_BLINK;
      c_PROG_READ, c_LOAD, c_INACTIVE, c_ACTIVE:        prog_led_d = c_LED_ON;
      default:                                          prog_led_d = c_LED_OFF;
    endcase
  end

  assign state_o       = state_q;
  assign ch_en_o       = ch_en_q;
  assign ufm_reset_n_o = ufm_reset_n_q;
  assign start_write_o = start_write_q;
  assign start_read_o  = start_read_q;
  assign start_load_o  = start_load_q;
  assign prog_led_o    = prog_led_q;
  assign fault_o       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_simps_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_simps_mode_ctrl
// Description : Self-checking bench for simps_mode_ctrl (NUM_CH=2,
//               UFM_RST_CYC=4, TIMEOUT=100, STAGE_DLY=256). Expected output
//               snapshots are queued as stimulus is applied and compared
//               against the registered outputs one clock later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simps_mode_ctrl;

`ifdef SIMPS_CTRL_OVERRIDE_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] en;
    logic       urn;
    logic       sw;
    logic       sr;
    logic       sl;
    logic [1:0] led;
    logic       flt;
  } snap_t;

  typedef struct packed {
    logic       rr, rl, er, el, wd, rd, ld, cs;
    logic [1:0] ovs;
    logic [1:0] ovv;
    logic       ovc;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sw_reset_rise, sw_reset, sw_enable_rise, sw_enable;
  logic       init_done, prog_ready, write_done, read_done, load_done, clk_stable;
  logic [1:0] ov_set, ov_val;
  logic       ov_clear;
  logic [1:0] ch_en;
  logic       ufm_reset_n, start_write, start_read, start_load, fault;
  logic [3:0] state;
  logic [1:0] prog_led;

  int    n_checks = 0;
  int    n_err    = 0;
  snap_t exp_q[$];

  simps_mode_ctrl #(
    .NUM_CH(2), .UFM_RST_CYC(4), .TIMEOUT(100), .STAGE_DLY(256)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .sw_reset_rise_i(sw_reset_rise), .sw_reset_i(sw_reset),
    .sw_enable_rise_i(sw_enable_rise), .sw_enable_i(sw_enable),
    .init_done_i(init_done), .prog_ready_i(prog_ready),
    .write_done_i(write_done), .read_done_i(read_done),
    .load_done_i(load_done), .clk_stable_i(clk_stable),
    .ov_set_i(ov_set), .ov_val_i(ov_val), .ov_clear_i(ov_clear),
    .ch_en_o(ch_en), .ufm_reset_n_o(ufm_reset_n),
    .start_write_o(start_write), .start_read_o(start_read),
    .start_load_o(start_load), .state_o(state),
    .prog_led_o(prog_led), .fault_o(fault)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [3:0] s, input logic [1:0] en,
                               input logic urn, sw, sr, sl,
                               input logic [1:0] led, input logic f);
    return {s, en, urn, sw, sr, sl, led, f};
  endfunction

  function automatic stim_t st(input logic rr, rl, er, el, wd, rd, ld, cs,
                               input logic [1:0] ovs, ovv, input logic ovc);
    return {rr, rl, er, el, wd, rd, ld, cs, ovs, ovv, ovc};
  endfunction

  function automatic snap_t snap();
    return {state, ch_en, ufm_reset_n, start_write, start_read, start_load,
            prog_led, fault};
  endfunction

  task automatic apply(input stim_t s);
    sw_reset_rise  = s.rr;
    sw_reset       = s.rl;
    sw_enable_rise = s.er;
    sw_enable      = s.el;
    write_done     = s.wd;
    read_done      = s.rd;
    load_done      = s.ld;
    clk_stable     = s.cs;
    ov_set         = s.ovs;
    ov_val         = s.ovv;
    ov_clear       = s.ovc;
  endtask

  task automatic test_reset();
    snap_t got, want;
    apply(st(0,0,0,0,0,0,0,0,2'b00,2'b00,0));
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(4'd0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    got = snap(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_held: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", got, want);
    end
    @(negedge clk) reset_n = 1'b1;
    exp_q.push_back(mk(4'd0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    @(posedge clk); #1;
    got = snap(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_released: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", got, want);
    end
  endtask

  task automatic test_bringup();
    stim_t sv[$]; snap_t xv[$]; snap_t got, want;
    sv.push_back(st(1,1,0,0,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    sv.push_back(st(0,1,1,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    for (int i = 0; i < 3; i++) begin
      sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    end
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(2, 2'b00, 1, 0, 0, 0, 2'b01, 0));
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(3, 2'b00, 1, 1, 0, 0, 2'b01, 0));
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(3, 2'b00, 1, 0, 0, 0, 2'b01, 0));
    foreach (sv[i]) begin
      apply(sv[i]); exp_q.push_back(xv[i]);
      @(posedge clk); #1;
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL bringup step %0d: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", i, got, want);
      end
    end
  endtask

  task automatic test_program_flow();
    stim_t sv[$]; snap_t xv[$]; snap_t got, want;
    sv.push_back(st(0,1,0,1,1,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(4, 2'b00, 1, 0, 1, 0, 2'b10, 0));
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(4, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,1,0,1,0,1,0,0,2'b00,2'b00,0)); xv.push_back(mk(5, 2'b00, 1, 0, 0, 1, 2'b10, 0));
    sv.push_back(st(0,1,0,1,0,0,1,0,2'b00,2'b00,0)); xv.push_back(mk(5, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,1,0,2'b00,2'b00,0)); xv.push_back(mk(6, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(6, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    foreach (sv[i]) begin
      apply(sv[i]); exp_q.push_back(xv[i]);
      @(posedge clk); #1;
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL program_flow step %0d: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", i, got, want);
      end
    end
  endtask

  task automatic test_override();
    stim_t sv[$]; snap_t xv[$]; snap_t got, want;
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b01,2'b01,0)); xv.push_back(mk(6, OV_EN ? 2'b01 : 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(6, OV_EN ? 2'b01 : 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b10,2'b10,0)); xv.push_back(mk(6, OV_EN ? 2'b11 : 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b01,2'b00,0)); xv.push_back(mk(6, OV_EN ? 2'b10 : 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b01,2'b01,1)); xv.push_back(mk(6, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b11,2'b11,0)); xv.push_back(mk(6, OV_EN ? 2'b11 : 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b00,2'b00,1)); xv.push_back(mk(6, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    foreach (sv[i]) begin
      apply(sv[i]); exp_q.push_back(xv[i]);
      @(posedge clk); #1;
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL override step %0d: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", i, got, want);
      end
    end
  endtask

  task automatic test_active();
    stim_t sv[$]; snap_t xv[$]; snap_t got, want;
    sv.push_back(st(0,0,1,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(7, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    for (int i = 0; i < 3; i++) begin
      sv.push_back(st(0,0,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(7, 2'b01, 1, 0, 0, 0, 2'b10, 0));
    end
    // clk_stable raised for 100 cycles then dropped; ch 1 due 257 cycles on
    for (int i = 1; i <= 257; i++) begin
      sv.push_back(st(0,0,0,1,0,0,0,(i <= 100),2'b00,2'b00,0));
      xv.push_back(mk(7, (i == 257) ? 2'b11 : 2'b01, 1, 0, 0, 0, 2'b10, 0));
    end
    for (int i = 0; i < 2; i++) begin
      sv.push_back(st(0,0,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(7, 2'b11, 1, 0, 0, 0, 2'b10, 0));
    end
    sv.push_back(st(0,0,0,0,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(4, 2'b00, 1, 0, 1, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,1,0,0,2'b00,2'b00,0)); xv.push_back(mk(5, 2'b00, 1, 0, 0, 1, 2'b10, 0));
    sv.push_back(st(0,0,0,0,0,0,1,0,2'b00,2'b00,0)); xv.push_back(mk(6, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    foreach (sv[i]) begin
      apply(sv[i]); exp_q.push_back(xv[i]);
      @(posedge clk); #1;
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL active step %0d: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_stage();
    stim_t sv[$]; snap_t xv[$]; snap_t got, want;
    sv.push_back(st(0,0,1,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(7, 2'b00, 1, 0, 0, 0, 2'b10, 0));
    sv.push_back(st(0,0,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(7, 2'b01, 1, 0, 0, 0, 2'b10, 0));
    for (int i = 0; i < 5; i++) begin
      sv.push_back(st(0,0,0,1,0,0,0,1,2'b00,2'b00,0)); xv.push_back(mk(7, 2'b01, 1, 0, 0, 0, 2'b10, 0));
    end
    sv.push_back(st(1,1,0,1,0,0,0,1,2'b00,2'b00,0)); xv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    foreach (sv[i]) begin
      apply(sv[i]); exp_q.push_back(xv[i]);
      @(posedge clk); #1;
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid_stage step %0d: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", i, got, want);
      end
    end
  endtask

  task automatic test_watchdog();
    stim_t sv[$]; snap_t xv[$]; snap_t got, want;
    sv.push_back(st(0,1,1,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    for (int i = 0; i < 3; i++) begin
      sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    end
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(2, 2'b00, 1, 0, 0, 0, 2'b01, 0));
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(3, 2'b00, 1, 1, 0, 0, 2'b01, 0));
    // No write_done: the hundredth cycle in PROG_WRITE lands in FAULT
    for (int i = 1; i <= 100; i++) begin
      sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0));
      xv.push_back((i < 100) ? mk(3, 2'b00, 1, 0, 0, 0, 2'b01, 0)
                             : mk(8, 2'b00, 1, 0, 0, 0, 2'b00, 1));
    end
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b11,2'b11,0)); xv.push_back(mk(8, 2'b00, 1, 0, 0, 0, 2'b00, 1));
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(8, 2'b00, 1, 0, 0, 0, 2'b00, 1));
    sv.push_back(st(1,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    sv.push_back(st(0,1,0,1,0,0,0,0,2'b00,2'b00,0)); xv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
    foreach (sv[i]) begin
      apply(sv[i]); exp_q.push_back(xv[i]);
      @(posedge clk); #1;
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_err++;
        $display("FAIL watchdog step %0d: got %b, expected %b (st|en|urn|sw|sr|sl|led|flt)", i, got, want);
      end
    end
  endtask

  initial begin
    init_done  = 1'b1;
    prog_ready = 1'b1;
    test_reset();
    test_bringup();
    test_program_flow();
    test_override();
    test_active();
    test_reset_mid_stage();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/simps_mode_ctrl.md
# simps_mode_ctrl

Parametrised top-level mode controller for SIMPS. It sequences the instrument through reset, UFM programming, readback, peripheral load, inactive and active modes. It drives NUM_CH output-channel enables with staggered turn-on, and adds a per-state watchdog with a FAULT state. It also provides clocked, per-channel front-end overrides that replace the previous unclocked override latches. The block sits between the debounced front-panel switches, the FT245 protocol engine and the UFM, pot and clock sub-blocks.

## Interface
- NUM_CH, 2, number of output channels; ch 0 = power supply, ch 1..NUM_CH-1 = function-gen paths
- UFM_RST_CYC, 4, cycles ufm_reset_n is held low in UFM_RST
- TIMEOUT, 25000000, watchdog limit in cycles for states 1–5 and for enable staging
- STAGE_DLY, 256, cycles between successive channel enables in ACTIVE
- clk  in  1  system clock (CLK_25M domain)
- reset_n  in  1  asynchronous, active-low reset
- sw_reset_rise  in  1  one-cycle pulse, debounced reset switch rising edge
- sw_reset  in  1  debounced reset switch level
- sw_enable_rise  in  1  one-cycle pulse, debounced enable switch rising edge
- sw_enable  in  1  debounced enable switch level
- init_done  in  1  pot, clock and CSR initial config complete
- prog_ready  in  1  protocol has a complete program image
- write_done  in  1  UFM write complete
- read_done  in  1  UFM readback complete
- load_done  in  1  reference and frequency loaded into pot and clock
- clk_stable  in  1  SG clock running
- ov_set  in  NUM_CH  one-cycle per-channel override strobe from protocol
- ov_val  in  NUM_CH  override value, sampled with ov_set
- ov_clear  in  1  drop all overrides
- ch_en  out  NUM_CH  channel enables, after override muxing
- ufm_reset_n  out  1  UFM/ADC reset, active low
- start_write, start_read, start_load  out  1 each  one-cycle start pulses
- state  out  4  current state encoding
- prog_led  out  2  00 off, 01 blink, 10 on; feeds ledflash
- fault  out  1  high in FAULT

## Operation
- States:
  - 0 RST_WAIT: prog_led=01, ufm_reset_n=0. On sw_enable_rise && sw_reset, go to 1.
  - 1 UFM_RST: ufm_reset_n=0 for UFM_RST_CYC cycles, then 1. Go to 2 when the count is done.
  - 2 INIT_WAIT: on init_done && prog_ready, pulse start_write and go to 3.
  - 3 PROG_WRITE: prog_led=01. On write_done, set prog_led=10, pulse start_read and go to 4.
  - 4 PROG_READ: on read_done, pulse start_load and go to 5.
  - 5 LOAD: on load_done && !sw_reset && !sw_enable, go to 6.
  - 6 INACTIVE: FSM enables all 0. On sw_enable_rise && !sw_reset, go to 7.
  - 7 ACTIVE: ch 0 enabled on entry. Once clk_stable, ch k enables k·STAGE_DLY cycles after clk_stable first seen, in ascending order. On !sw_enable, all FSM enables clear, pulse start_read and go to 4.
  - 8 FAULT: prog_led=00, FSM enables 0, ufm_reset_n=1. Exit only via reset.
- Watchdog:
  - Counter clears on every state change.
  - It runs in states 1–5, and in 7 until clk_stable.
  - At TIMEOUT−1 the next state is FAULT.
  - Width is $clog2(TIMEOUT+1).
- Stage counter: width $clog2(NUM_CH·STAGE_DLY+1); saturates.
- Overrides (SIMPS_CTRL_OVERRIDE_EN):
  - ov_set[k] sets ov_act[k]=1 and ov_reg[k]=ov_val[k].
  - ch_en[k] = ov_act[k] ? ov_reg[k] : fsm_en[k].
  - Overrides are honoured in every state except FAULT, where ch_en=0.
- Priority, highest first: reset_n, sw_reset_rise, watchdog expiry, normal transition.
- sw_reset_rise in any state, including FAULT and mid-stage:
  - state goes to 0 and all counters clear;
  - ov_act clears and fsm_en clears;
  - no start pulse is issued.
- ov_clear and ov_set in the same cycle: ov_clear wins for all bits.

## Timing
- Reset values:
  - state=0, ch_en=0, ufm_reset_n=0, prog_led=01, fault=0;
  - start pulses 0, ov_act=0, ov_reg=0.
- All outputs are registered. A transition condition sampled in cycle n gives the new state and its start pulse in cycle n+1.
- Start pulses are exactly one cycle wide.
- ch_en reacts to ov_set one cycle later.
- ufm_reset_n is low for exactly UFM_RST_CYC cycles in state 1.
- ACTIVE staging:
  - ch 0 rises in the cycle after the state becomes 7;
  - ch k rises k·STAGE_DLY+1 cycles after the first clk_stable high sample.
  - clk_stable dropping after first seen does not reset staging.

## Configuration
- SIMPS_CTRL_OVERRIDE_EN defined: override registers and ov_* ports are active as described.
- Not defined: ov_set, ov_val and ov_clear are ignored, no override flops are built, and ch_en = fsm_en (FAULT still forces 0).

## Test plan
- reset_n low, release; assert sw_reset, then sw_enable_rise; hold init_done=prog_ready=1 → state sequence 0,1(4 cycles, ufm_reset_n=0),2,3 with start_write pulse one cycle after 2.
- Full program flow with write_done, read_done, load_done; drop switches; sw_enable_rise → state=7, ch_en=01. Raise clk_stable → ch_en=11 exactly 257 cycles later (NUM_CH=2, STAGE_DLY=256).
- TIMEOUT=100; sit in state 3 without write_done → state=8, fault=1 at cycle 100; sw_reset_rise → state=0, fault=0.
- Override build: in state 6, ov_set=01, ov_val=01 → ch_en=01 next cycle. ov_set and ov_clear in the same cycle → ch_en=00.
- sw_reset_rise during ACTIVE staging (ch_en=01) → state=0, ch_en=00, stage counter 0.
- Non-override build: ov_set=11, ov_val=11 in state 6 → ch_en stays 00.
